riscv_csr_arb: RTL and testbench
================================

// Module: riscv_csr_arb
// PURPOSE
//  Arbitrates and sequences access to the single CSR read/write port of the state unit between
//  the EX-stage pipeline requester and the debug-unit requester. Each access is a CSR read-modify-write:
//  CSRRW, CSRRS or CSRRC semantics, or a read only. Sits between riscv_state (CSR file) and the EX/debug logic.
// PARAMETERS
//  XLEN      32  datapath width
//  DBG_PRIO  1   1: debug has fixed priority; 0: round-robin between EX and debug
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  rst        in   1     synchronous, active-high reset
//  ex_req     in   1     EX access request; hold req/op/addr/wdata stable until ex_gnt
//  ex_op      in   2     00 READ, 01 WRITE, 10 SET, 11 CLEAR
//  ex_addr    in   12    CSR address
//  ex_wdata   in   XLEN  write value / set-clear mask
//  ex_gnt     out  1     combinational; request accepted this cycle
//  ex_done    out  1     registered 1-cycle pulse; ex_rdata/ex_err valid
//  ex_rdata   out  XLEN  old CSR value
//  ex_err     out  1     illegal CSR (csr_err seen in READ)
//  dbg_*      -    -     same set of signals as ex_* for the debug requester
//  csr_addr   out  12    to CSR file
//  csr_re     out  1     read strobe
//  csr_rval   in   XLEN  CSR read data, valid in the csr_re cycle
//  csr_err    in   1     illegal/inaccessible address, valid in the csr_re cycle
//  csr_we     out  1     write strobe
//  csr_wval   out  XLEN  write data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; rr pointer = DBG-last (EX wins first tie). csr_re/csr_we/gnt gated by ~rst.
//  - FSM IDLE -> READ -> [WRITE] -> RESP -> IDLE. gnt only in IDLE. Grant edge latches owner, op, addr, wdata.
//  - READ: csr_re=1, csr_addr=addr. rval and err are registered into resp_rdata and resp_err.
//    csr_err -> RESP with err=1; no write.
//    op READ -> RESP. SET/CLEAR with mask==0 -> RESP; no write.
//    Otherwise -> WRITE.
//  - WRITE: csr_we=1 for exactly 1 cycle. csr_wval is the value computed from the registered rval:
//    WRITE=wdata, SET=rval|wdata, CLEAR=rval&~wdata.
//    WRITE op with csr_err never writes.
//  - RESP: owner's done=1 for one cycle. rdata/err are held until the next done; the non-owner's done stays 0.
//  - Latency, counted from gnt cycle N: read-only or suppressed write gives done at N+2; RMW gives done at N+3.
//    Min issue interval 3 cycles (read-only) / 4 (RMW).
//  - Arbitration:
//    DBG_PRIO=1: dbg wins whenever both request.
//    DBG_PRIO=0: the winner is the requester that was not granted last; the pointer updates on each grant.
//  - Requests arriving while busy are held off (gnt=0); no queueing. Dropping req before gnt is legal and has no effect.
//  - Mid-operation reset: the access is abandoned. A pending WRITE is never issued; no done pulse.
//  - csr_addr/csr_wval hold their last values when idle; consumers must qualify them with re/we.
// STRUCTURE
//  - riscv_state_pkg gets:
//    csr_op_t enum {CSR_RD, CSR_WR, CSR_SET, CSR_CLR}
//    csr_arb_state_t {IDLE, READ, WRITE, RESP}
//    owner encoding
//  - One sub-module: riscv_rr_arb2 (2-way arbiter with fixed/round-robin mode and a pointer register).
//    The FSM and datapath stay in this module.
// TESTING
//  1. EX only, op=SET, addr=0x300, rval=0x8, wdata=0x2
//     -> gnt@N, re@N+1, we@N+2 with wval=0x0A, ex_done@N+3, rdata=0x8, err=0.
//  2. DBG op=CLEAR, wdata=0
//     -> no csr_we, dbg_done@N+2, rdata=CSR value.
//     Then op=WRITE, wdata=0 -> csr_we=1, wval=0.
//  3. Both req every cycle, DBG_PRIO=0
//     -> grants alternate EX, DBG, EX...; DBG_PRIO=1 -> dbg granted every time.
//  4. csr_err=1 during READ, op=WRITE
//     -> no csr_we, done@N+2 with err=1; next access has err=0.
//  5. rst asserted in the WRITE cycle
//     -> csr_we=0 that cycle, no done, state IDLE; the next EX request is granted in the first cycle after rst drops.
//  6. EX req asserted while DBG in flight, then held
//     -> ex_gnt only in the IDLE cycle following dbg_done; ex fields latched from that cycle.

Source files
------------

// File: rtl/riscv_state_pkg.sv
// Shared types for the CSR access path of the state unit.
//   csr_op_t        : read-modify-write flavour requested by EX / debug
//   csr_arb_state_t : sequencing states of the CSR port arbiter
//   csr_owner_t     : which requester currently owns the CSR port
//   csr_op_writes() : does an access of this op actually write the CSR
package riscv_state_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef enum logic [1:0] {
        CSR_RD  = 2'b00,
        CSR_WR  = 2'b01,
        CSR_SET = 2'b10,
        CSR_CLR = 2'b11
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } csr_arb_state_t;

    typedef enum logic {
        OWNER_EX  = 1'b0,
        OWNER_DBG = 1'b1
    } csr_owner_t;

    // SET/CLEAR with an all-zero mask cannot change the CSR, so the write is skipped.
    function automatic logic csr_op_writes(input csr_op_t op, input logic mask_zero);
        logic wr;
        case (op)
            CSR_RD:  wr = 1'b0;
            CSR_WR:  wr = 1'b1;
            CSR_SET: wr = ~mask_zero;
            CSR_CLR: wr = ~mask_zero;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way request arbiter with a last-granted pointer.
//   clk_i/rst_i : clock, synchronous active-high reset
//   en_i        : grants may only be issued when high
//   req0_i/1_i  : requests (0 = EX side, 1 = debug side)
//   gnt0_o/1_o  : combinational one-hot grant
// FIXED_PRIO=1 gives requester 1 fixed priority; 0 alternates on ties.
module riscv_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // 1: requester 1 was granted last, so requester 0 wins the next tie
    logic last1_q;
    logic last1_d;

    // Grant selection
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (req0_i && req1_i) begin
                if (FIXED_PRIO) begin
                    gnt1_o = 1'b1;
                end else if (last1_q) begin
                    gnt0_o = 1'b1;
                end else begin
                    gnt1_o = 1'b1;
                end
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end else begin
            gnt0_o = 1'b0;
            gnt1_o = 1'b0;
        end
    end

    // Pointer next state: follows every grant
    always_comb begin
        last1_d = last1_q;
        if (gnt0_o) begin
            last1_d = 1'b0;
        end else if (gnt1_o) begin
            last1_d = 1'b1;
        end else begin
            last1_d = last1_q;
        end
    end

    // Pointer register; reset as if requester 1 went last
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end

endmodule

// File: rtl/riscv_csr_arb.sv
// Arbitrates the single CSR read/write port of the state unit between the
// EX-stage requester and the debug requester, performing READ / WRITE / SET /
// CLEAR accesses as read-modify-write sequences IDLE -> READ -> [WRITE] -> RESP.
//   clk, rst                 : clock, synchronous active-high reset
//   ex_*/dbg_* req/op/addr/wdata : requester inputs, held until gnt
//   ex_*/dbg_* gnt           : combinational accept (IDLE only)
//   ex_*/dbg_* done/rdata/err: registered response (old CSR value, illegal flag)
//   csr_addr/re/rval/err     : CSR file read side
//   csr_we/wval              : CSR file write side
module riscv_csr_arb
    import riscv_state_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit DBG_PRIO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_req,
    input  logic [1:0]            ex_op,
    input  logic [CSR_ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]       ex_wdata,
    output logic                  ex_gnt,
    output logic                  ex_done,
    output logic [XLEN-1:0]       ex_rdata,
    output logic                  ex_err,
    input  logic                  dbg_req,
    input  logic [1:0]            dbg_op,
    input  logic [CSR_ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_done,
    output logic [XLEN-1:0]       dbg_rdata,
    output logic                  dbg_err,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic                  csr_re,
    input  logic [XLEN-1:0]       csr_rval,
    input  logic                  csr_err,
    output logic                  csr_we,
    output logic [XLEN-1:0]       csr_wval
);

    csr_arb_state_t        state_q,      state_d;
    csr_owner_t            owner_q,      owner_d;
    csr_op_t               op_q,         op_d;
    logic [CSR_ADDR_W-1:0] addr_q,       addr_d;
    logic [XLEN-1:0]       wdata_q,      wdata_d;
    logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q,   resp_err_d;
    logic [XLEN-1:0]       wval_q,       wval_d;
    logic                  ex_done_q,    ex_done_d;
    logic [XLEN-1:0]       ex_rdata_q,   ex_rdata_d;
    logic                  ex_err_q,     ex_err_d;
    logic                  dbg_done_q,   dbg_done_d;
    logic [XLEN-1:0]       dbg_rdata_q,  dbg_rdata_d;
    logic                  dbg_err_q,    dbg_err_d;
    logic                  arb_en_s;
    logic                  resp_enter_s;

    // Grants are only possible from IDLE and never while reset is asserted
    assign arb_en_s = (state_q == IDLE) && !rst;

    riscv_rr_arb2 #(
        .FIXED_PRIO (DBG_PRIO)
    ) u_arb (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (arb_en_s),
        .req0_i (ex_req),
        .req1_i (dbg_req),
        .gnt0_o (ex_gnt),
        .gnt1_o (dbg_gnt)
    );

    assign csr_re    = (state_q == READ)  && !rst;
    assign csr_we    = (state_q == WRITE) && !rst;
    assign csr_addr  = addr_q;
    assign csr_wval  = wval_q;
    assign ex_done   = ex_done_q;
    assign ex_rdata  = ex_rdata_q;
    assign ex_err    = ex_err_q;
    assign dbg_done  = dbg_done_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_err   = dbg_err_q;

    // FSM next state, request latching and RMW datapath
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wval_d       = wval_q;
        case (state_q)
            IDLE: begin
                if (dbg_gnt) begin
                    state_d = READ;
                    owner_d = OWNER_DBG;
                    op_d    = csr_op_t'(dbg_op);
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                end else if (ex_gnt) begin
                    state_d = READ;
                    owner_d = OWNER_EX;
                    op_d    = csr_op_t'(ex_op);
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                resp_rdata_d = csr_rval;
                resp_err_d   = csr_err;
                if (csr_err) begin
                    state_d = RESP;
                end else if (csr_op_writes(op_q, (wdata_q == {XLEN{1'b0}}))) begin
                    state_d = WRITE;
                    // Precompute the write value from the value captured this cycle
                    case (op_q)
                        CSR_SET: wval_d = csr_rval | wdata_q;
                        CSR_CLR: wval_d = csr_rval & ~wdata_q;
                        default: wval_d = wdata_q;
                    endcase
                end else begin
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers load on entry to RESP so done and data appear together
    always_comb begin
        resp_enter_s = (state_d == RESP) && (state_q != RESP);
        ex_done_d    = resp_enter_s && (owner_q == OWNER_EX);
        dbg_done_d   = resp_enter_s && (owner_q == OWNER_DBG);
        ex_rdata_d   = ex_rdata_q;
        ex_err_d     = ex_err_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_err_d    = dbg_err_q;
        if (ex_done_d) begin
            ex_rdata_d = resp_rdata_d;
            ex_err_d   = resp_err_d;
        end else if (dbg_done_d) begin
            dbg_rdata_d = resp_rdata_d;
            dbg_err_d   = resp_err_d;
        end else begin
            ex_rdata_d = ex_rdata_q;
        end
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_EX;
            op_q         <= CSR_RD;
            addr_q       <= {CSR_ADDR_W{1'b0}};
            wdata_q      <= {XLEN{1'b0}};
            resp_rdata_q <= {XLEN{1'b0}};
            resp_err_q   <= 1'b0;
            wval_q       <= {XLEN{1'b0}};
            ex_done_q    <= 1'b0;
            ex_rdata_q   <= {XLEN{1'b0}};
            ex_err_q     <= 1'b0;
            dbg_done_q   <= 1'b0;
            dbg_rdata_q  <= {XLEN{1'b0}};
            dbg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wval_q       <= wval_d;
            ex_done_q    <= ex_done_d;
            ex_rdata_q   <= ex_rdata_d;
            ex_err_q     <= ex_err_d;
            dbg_done_q   <= dbg_done_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_csr_arb.sv
// Directed bench for riscv_csr_arb. u0 runs round-robin (DBG_PRIO=0),
// u1 runs fixed debug priority; both see identical stimulus.
module tb_riscv_csr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req, dbg_req, csr_err;
    logic [1:0]  ex_op, dbg_op;
    logic [11:0] ex_addr, dbg_addr;
    logic [31:0] ex_wdata, dbg_wdata, csr_rval;

    logic        ex_gnt, ex_done, ex_err, dbg_gnt, dbg_done, dbg_err, csr_re, csr_we;
    logic [31:0] ex_rdata, dbg_rdata, csr_wval;
    logic [11:0] csr_addr;

    logic        u1_ex_gnt, u1_ex_done, u1_ex_err, u1_dbg_gnt, u1_dbg_done, u1_dbg_err;
    logic        u1_csr_re, u1_csr_we;
    logic [31:0] u1_ex_rdata, u1_dbg_rdata, u1_csr_wval;
    logic [11:0] u1_csr_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_csr_arb #(.XLEN(32), .DBG_PRIO(1'b0)) u0 (
        .clk(clk), .rst(rst),
        .ex_req(ex_req), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_gnt(ex_gnt), .ex_done(ex_done), .ex_rdata(ex_rdata), .ex_err(ex_err),
        .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .csr_addr(csr_addr), .csr_re(csr_re), .csr_rval(csr_rval), .csr_err(csr_err),
        .csr_we(csr_we), .csr_wval(csr_wval)
    );

    riscv_csr_arb #(.XLEN(32), .DBG_PRIO(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .ex_req(ex_req), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_gnt(u1_ex_gnt), .ex_done(u1_ex_done), .ex_rdata(u1_ex_rdata), .ex_err(u1_ex_err),
        .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(u1_dbg_gnt), .dbg_done(u1_dbg_done), .dbg_rdata(u1_dbg_rdata), .dbg_err(u1_dbg_err),
        .csr_addr(u1_csr_addr), .csr_re(u1_csr_re), .csr_rval(csr_rval), .csr_err(csr_err),
        .csr_we(u1_csr_we), .csr_wval(u1_csr_wval)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge (input drive point)
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // advance to the falling edge (sample point)
    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ex_req = 1'b1; dbg_req = 1'b0; csr_err = 1'b0;
        ex_op = 2'b00; dbg_op = 2'b00; ex_addr = 12'h000; dbg_addr = 12'h000;
        ex_wdata = 32'h0; dbg_wdata = 32'h0; csr_rval = 32'h0;

        // reset: everything quiet, request gated
        nxt; nxt; smp;
        chk("rst_ex_gnt", {31'd0, ex_gnt}, 32'd0);
        chk("rst_csr_re", {31'd0, csr_re}, 32'd0);
        chk("rst_ex_done", {31'd0, ex_done}, 32'd0);
        chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        chk("rst_ex_rdata", ex_rdata, 32'd0);
        nxt; rst = 1'b0; ex_req = 1'b0;

        // 1: EX SET, rval 0x8 mask 0x2
        nxt; ex_req = 1'b1; ex_op = 2'b10; ex_addr = 12'h300; ex_wdata = 32'h2; csr_rval = 32'h8;
        smp;
        chk("t1_ex_gnt", {31'd0, ex_gnt}, 32'd1);
        chk("t1_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("t1_re_n", {31'd0, csr_re}, 32'd0);
        nxt; ex_req = 1'b0; smp;
        chk("t1_re", {31'd0, csr_re}, 32'd1);
        chk("t1_addr", {20'd0, csr_addr}, 32'h300);
        chk("t1_we_n1", {31'd0, csr_we}, 32'd0);
        nxt; smp;
        chk("t1_we", {31'd0, csr_we}, 32'd1);
        chk("t1_wval", csr_wval, 32'h0A);
        chk("t1_done_n2", {31'd0, ex_done}, 32'd0);
        nxt; smp;
        chk("t1_done", {31'd0, ex_done}, 32'd1);
        chk("t1_rdata", ex_rdata, 32'h8);
        chk("t1_err", {31'd0, ex_err}, 32'd0);
        chk("t1_we_n3", {31'd0, csr_we}, 32'd0);
        nxt; smp;
        chk("t1_done_off", {31'd0, ex_done}, 32'd0);
        chk("t1_rdata_hold", ex_rdata, 32'h8);

        // 2: DBG CLEAR with zero mask -> no write
        nxt; dbg_req = 1'b1; dbg_op = 2'b11; dbg_addr = 12'h305; dbg_wdata = 32'h0; csr_rval = 32'h55;
        smp;
        chk("t2_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("t2_ex_gnt", {31'd0, ex_gnt}, 32'd0);
        nxt; dbg_req = 1'b0; smp;
        chk("t2_re", {31'd0, csr_re}, 32'd1);
        chk("t2_addr", {20'd0, csr_addr}, 32'h305);
        nxt; smp;
        chk("t2_dbg_done", {31'd0, dbg_done}, 32'd1);
        chk("t2_dbg_rdata", dbg_rdata, 32'h55);
        chk("t2_we_n", {31'd0, csr_we}, 32'd0);
        chk("t2_ex_done_n", {31'd0, ex_done}, 32'd0);
        chk("t2_ex_rdata_hold", ex_rdata, 32'h8);
        // 2b: DBG WRITE of zero does write
        nxt; dbg_req = 1'b1; dbg_op = 2'b01; dbg_wdata = 32'h0; csr_rval = 32'h77;
        smp;
        chk("t2b_gnt", {31'd0, dbg_gnt}, 32'd1);
        nxt; dbg_req = 1'b0; smp;
        chk("t2b_re", {31'd0, csr_re}, 32'd1);
        nxt; smp;
        chk("t2b_we", {31'd0, csr_we}, 32'd1);
        chk("t2b_wval", csr_wval, 32'h0);
        nxt; smp;
        chk("t2b_done", {31'd0, dbg_done}, 32'd1);
        chk("t2b_rdata", dbg_rdata, 32'h77);

        // 3: both request continuously, read-only
        nxt; ex_req = 1'b1; dbg_req = 1'b1; ex_op = 2'b00; dbg_op = 2'b00; csr_rval = 32'h11;
        smp;
        chk("t3_rr_g1_ex", {31'd0, ex_gnt}, 32'd1);
        chk("t3_rr_g1_dbg", {31'd0, dbg_gnt}, 32'd0);
        chk("t3_fx_g1_dbg", {31'd0, u1_dbg_gnt}, 32'd1);
        chk("t3_fx_g1_ex", {31'd0, u1_ex_gnt}, 32'd0);
        nxt; smp;
        chk("t3_busy_ex", {31'd0, ex_gnt}, 32'd0);
        chk("t3_busy_dbg", {31'd0, dbg_gnt}, 32'd0);
        nxt; smp;
        chk("t3_rr_done1", {31'd0, ex_done}, 32'd1);
        nxt; smp;
        chk("t3_rr_g2_dbg", {31'd0, dbg_gnt}, 32'd1);
        chk("t3_rr_g2_ex", {31'd0, ex_gnt}, 32'd0);
        chk("t3_fx_g2_dbg", {31'd0, u1_dbg_gnt}, 32'd1);
        nxt; nxt; nxt; smp;
        chk("t3_rr_g3_ex", {31'd0, ex_gnt}, 32'd1);
        chk("t3_rr_g3_dbg", {31'd0, dbg_gnt}, 32'd0);
        chk("t3_fx_g3_dbg", {31'd0, u1_dbg_gnt}, 32'd1);
        nxt; ex_req = 1'b0; dbg_req = 1'b0;
        nxt;

        // 4: csr_err during READ of a WRITE op
        nxt; ex_req = 1'b1; ex_op = 2'b01; ex_addr = 12'h340; ex_wdata = 32'h1234;
        csr_rval = 32'hDEAD; csr_err = 1'b1;
        smp;
        chk("t4_gnt", {31'd0, ex_gnt}, 32'd1);
        nxt; ex_req = 1'b0; smp;
        chk("t4_re", {31'd0, csr_re}, 32'd1);
        nxt; csr_err = 1'b0; smp;
        chk("t4_we_n", {31'd0, csr_we}, 32'd0);
        chk("t4_done", {31'd0, ex_done}, 32'd1);
        chk("t4_err", {31'd0, ex_err}, 32'd1);
        chk("t4_rdata", ex_rdata, 32'hDEAD);
        nxt; ex_req = 1'b1; ex_op = 2'b00; csr_rval = 32'h42; smp;
        chk("t4b_gnt", {31'd0, ex_gnt}, 32'd1);
        nxt; ex_req = 1'b0;
        nxt; smp;
        chk("t4b_done", {31'd0, ex_done}, 32'd1);
        chk("t4b_err", {31'd0, ex_err}, 32'd0);
        chk("t4b_rdata", ex_rdata, 32'h42);

        // 5: reset in the WRITE cycle
        nxt; ex_req = 1'b1; ex_op = 2'b10; ex_wdata = 32'h1; csr_rval = 32'h10; smp;
        chk("t5_gnt", {31'd0, ex_gnt}, 32'd1);
        nxt; ex_req = 1'b0; smp;
        chk("t5_re", {31'd0, csr_re}, 32'd1);
        nxt; rst = 1'b1; smp;
        chk("t5_we_gated", {31'd0, csr_we}, 32'd0);
        chk("t5_done_n1", {31'd0, ex_done}, 32'd0);
        nxt; smp;
        chk("t5_done_n2", {31'd0, ex_done}, 32'd0);
        chk("t5_re_n", {31'd0, csr_re}, 32'd0);
        chk("t5_we_n", {31'd0, csr_we}, 32'd0);
        nxt; rst = 1'b0; ex_req = 1'b1; ex_op = 2'b00; csr_rval = 32'h33; smp;
        chk("t5_gnt_after", {31'd0, ex_gnt}, 32'd1);
        nxt; ex_req = 1'b0;
        nxt; smp;
        chk("t5_done_after", {31'd0, ex_done}, 32'd1);
        chk("t5_rdata_after", ex_rdata, 32'h33);

        // 6: EX request held off while DBG is in flight
        nxt; dbg_req = 1'b1; dbg_op = 2'b00; dbg_addr = 12'h7B0; csr_rval = 32'h99; smp;
        chk("t6_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        nxt; dbg_req = 1'b0; ex_req = 1'b1; ex_op = 2'b11; ex_addr = 12'h341; ex_wdata = 32'h0F; smp;
        chk("t6_ex_held1", {31'd0, ex_gnt}, 32'd0);
        nxt; smp;
        chk("t6_dbg_done", {31'd0, dbg_done}, 32'd1);
        chk("t6_dbg_rdata", dbg_rdata, 32'h99);
        chk("t6_ex_held2", {31'd0, ex_gnt}, 32'd0);
        nxt; ex_addr = 12'h342; csr_rval = 32'hFF; smp;
        chk("t6_ex_gnt", {31'd0, ex_gnt}, 32'd1);
        nxt; ex_req = 1'b0; ex_addr = 12'h000; ex_wdata = 32'h0; smp;
        chk("t6_re", {31'd0, csr_re}, 32'd1);
        chk("t6_addr", {20'd0, csr_addr}, 32'h342);
        nxt; smp;
        chk("t6_we", {31'd0, csr_we}, 32'd1);
        chk("t6_wval", csr_wval, 32'hF0);
        nxt; smp;
        chk("t6_ex_done", {31'd0, ex_done}, 32'd1);
        chk("t6_ex_rdata", ex_rdata, 32'hFF);
        chk("t6_dbg_done_n", {31'd0, dbg_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
